// File: rtl/boa_peri_pmu_seq.sv
// Memory-mapped power sequencer: timed reset pulse, ordered shutdown and one-at-a-time domain switching.
// Optional CTRL write key check is enabled by defining BOA_PMU_KEY_EN.
module boa_peri_pmu_seq #(
    parameter int unsigned        DOMAINS       = 4,
    parameter int unsigned        DELAY_W       = 16,
    parameter int unsigned        DEF_DELAY     = 100,
    parameter int unsigned        RST_CYCLES    = 16,
    parameter logic [DOMAINS-1:0] RESET_DOMAINS = {DOMAINS{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_re,
    input  logic [3:0]         bus_we,
    input  logic [3:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               bus_ready,
    output logic               pmb_rst,
    output logic               pmb_shdn,
    output logic [DOMAINS-1:0] pwr_en,
    output logic               busy
);

    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STEP     = 3'd1,
        S_RST_HOLD = 3'd2,
        S_SHDN_SEQ = 3'd3,
        S_OFF      = 3'd4
    } state_t;

    state_t             state;
    logic [DOMAINS-1:0] domain_en;
    logic [DELAY_W-1:0] delay;
    logic [DELAY_W-1:0] cnt;
    logic [RCW-1:0]     rst_cnt;
    logic               key_ok;
    logic               key_err;
    logic [1:0]         word;
    logic               wr;
    logic               ctrl_wr;
    logic               rst_req;
    logic               shdn_req;
    logic [DELAY_W-1:0] step_len;
    logic [DOMAINS-1:0] diff;
    logic [DOMAINS-1:0] lowest;
    logic [1:0]         state_code;
    logic [31:0]        rd_data;
    logic               unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DOMAINS-1:0] top_bit(input logic [DOMAINS-1:0] v);
        logic [DOMAINS-1:0] m;
        m = '0;
        for (int i = 0; i < DOMAINS; i++) begin
            if (v[i]) begin
                m    = '0;
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

`ifdef BOA_PMU_KEY_EN
    assign key_ok = (bus_wdata[31:16] == 16'hB0A5) && (bus_we[3:2] == 2'b11);

    // Sticky flag for CTRL writes with a bad key; any good-key write clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         key_err <= 1'b0;
        else if (ctrl_wr) key_err <= !key_ok;
    end
`else
    assign key_ok  = 1'b1;
    assign key_err = 1'b0;
`endif

    assign bus_ready   = 1'b1;
    assign unused_addr = ^bus_addr[1:0];
    assign word        = bus_addr[3:2];
    assign wr          = |bus_we;
    assign ctrl_wr     = wr && (word == 2'd0) && (state != S_OFF);
    assign rst_req     = ctrl_wr && key_ok && bus_we[0] && bus_wdata[0];
    assign shdn_req    = ctrl_wr && key_ok && bus_we[0] && bus_wdata[1] && !bus_wdata[0];
    assign step_len    = (delay == '0) ? DELAY_W'(1) : delay;
    assign diff        = pwr_en ^ domain_en;
    assign lowest      = diff & (~diff + DOMAINS'(1));
    assign state_code  = (state == S_OFF) ? 2'd3 : state[1:0];
    assign busy        = (state != S_IDLE) || (pwr_en != domain_en);

    always_comb begin
        rd_data = '0;
        case (word)
            2'd1: begin
                rd_data[1:0]          = state_code;
                rd_data[8 +: DOMAINS] = pwr_en;
                rd_data[31]           = key_err;
            end
            2'd2:    rd_data[DOMAINS-1:0] = domain_en;
            2'd3:    rd_data[DELAY_W-1:0] = delay;
            default: rd_data = '0;
        endcase
    end

    // Register file, bus read port and sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            domain_en <= RESET_DOMAINS;
            delay     <= DELAY_W'(DEF_DELAY);
            cnt       <= '0;
            rst_cnt   <= '0;
            pwr_en    <= '0;
            pmb_rst   <= 1'b0;
            pmb_shdn  <= 1'b0;
            bus_rdata <= '0;
        end else begin
            if (bus_re) bus_rdata <= rd_data;
            if (wr && word == 2'd2 && state != S_SHDN_SEQ && state != S_OFF)
                domain_en <= DOMAINS'(merge(32'(domain_en), bus_wdata, bus_we));
            if (wr && word == 2'd3 && state != S_OFF)
                delay <= DELAY_W'(merge(32'(delay), bus_wdata, bus_we));

            if (rst_req) begin
                state   <= S_RST_HOLD;
                pmb_rst <= 1'b1;
                rst_cnt <= RCW'(RST_CYCLES);
            end else if (shdn_req && (state == S_IDLE || state == S_STEP)) begin
                state     <= S_SHDN_SEQ;
                domain_en <= '0;
                cnt       <= step_len;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (diff != '0) begin
                            pwr_en <= pwr_en ^ lowest;
                            cnt    <= step_len;
                            state  <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        if (cnt <= DELAY_W'(1)) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    S_RST_HOLD: begin
                        if (rst_cnt <= RCW'(1)) begin
                            rst_cnt <= '0;
                            pmb_rst <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            rst_cnt <= rst_cnt - RCW'(1);
                        end
                    end
                    S_SHDN_SEQ: begin
                        // Shutdown asserts one cycle after the last domain drops.
                        if (pwr_en == '0) begin
                            pmb_shdn <= 1'b1;
                            state    <= S_OFF;
                        end else if (cnt <= DELAY_W'(1)) begin
                            pwr_en <= pwr_en & ~top_bit(pwr_en);
                            cnt    <= step_len;
                        end else begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    S_OFF:   state <= S_OFF;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boa_peri_pmu_seq.sv
// Directed bench for boa_peri_pmu_seq: register table plus hand-timed sequencing scenarios.
module tb_boa_peri_pmu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bus_re = 1'b0;
    logic [3:0]  bus_we = '0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        pmb_rst;
    logic        pmb_shdn;
    logic [3:0]  pwr_en;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef BOA_PMU_KEY_EN
    localparam logic [31:0] KEY = 32'hB0A5_0000;
`else
    localparam logic [31:0] KEY = 32'h0000_0000;
`endif

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  we;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl [13];
    logic [3:0] shdn_steps [4];

    boa_peri_pmu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .pmb_rst   (pmb_rst),
        .pmb_shdn  (pmb_shdn),
        .pwr_en    (pwr_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [3:0] we, input logic [31:0] data);
        bus_addr  = addr;
        bus_we    = we;
        bus_wdata = data;
        tick();
        bus_we    = '0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        bus_addr = addr;
        bus_re   = 1'b1;
        tick();
        bus_re   = 1'b0;
        data     = bus_rdata;
    endtask

    task automatic ctrl(input logic [1:0] req);
        bus_write(4'h0, 4'hF, KEY | 32'(req));
    endtask

    task automatic wait_change(input logic [3:0] from, input int limit, output int n);
        n = 0;
        while (pwr_en == from && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic measure_pulse(input logic [3:0] hold, output int n, output int bad);
        n   = 0;
        bad = 0;
        while (pmb_rst && n < 100) begin
            if (pwr_en !== hold) bad++;
            n++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        int          bad;

        tbl[0]  = '{1'b0, 4'h0, 4'h0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 4'h4, 4'h0, 32'h0,         32'h0000_0F00};
        tbl[2]  = '{1'b0, 4'h8, 4'h0, 32'h0,         32'h0000_000F};
        tbl[3]  = '{1'b0, 4'hC, 4'h0, 32'h0,         32'h0000_0064};
        tbl[4]  = '{1'b1, 4'hC, 4'h1, 32'hFFFF_1234, 32'h0};
        tbl[5]  = '{1'b0, 4'hC, 4'h0, 32'h0,         32'h0000_0034};
        tbl[6]  = '{1'b1, 4'hC, 4'h2, 32'h0000_0500, 32'h0};
        tbl[7]  = '{1'b0, 4'hC, 4'h0, 32'h0,         32'h0000_0534};
        tbl[8]  = '{1'b1, 4'hC, 4'hF, 32'hABCD_0003, 32'h0};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 32'h0,         32'h0000_0003};
        tbl[10] = '{1'b1, 4'h8, 4'h2, 32'hFFFF_FF00, 32'h0};
        tbl[11] = '{1'b0, 4'h8, 4'h0, 32'h0,         32'h0000_000F};
        tbl[12] = '{1'b0, 4'h6, 4'h0, 32'h0,         32'h0000_0F00};
        shdn_steps = '{4'h7, 4'h3, 4'h1, 4'h0};

        // Reset state
        tick();
        tick();
        check("rst_pmb_rst", 32'(pmb_rst), 32'h0);
        check("rst_pmb_shdn", 32'(pmb_shdn), 32'h0);
        check("rst_pwr_en", 32'(pwr_en), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("bus_ready", 32'(bus_ready), 32'h1);

        // Power-up ramp at DELAY+1 spacing
        rst = 1'b1;
        wait_change(4'h0, 10, n);
        check("pu_first_lat", 32'(n), 32'd1);
        check("pu_val0", 32'(pwr_en), 32'h1);
        wait_change(4'h1, 200, n);
        check("pu_gap1", 32'(n), 32'd101);
        check("pu_val1", 32'(pwr_en), 32'h3);
        wait_change(4'h3, 200, n);
        check("pu_gap2", 32'(n), 32'd101);
        check("pu_val2", 32'(pwr_en), 32'h7);
        wait_change(4'h7, 200, n);
        check("pu_gap3", 32'(n), 32'd101);
        check("pu_val3", 32'(pwr_en), 32'hF);
        check("pu_busy_last", 32'(busy), 32'h1);
        wait_idle(200, n);
        check("pu_busy_drop", 32'(n), 32'd100);

        // Reset pulse
        check("pulse_pre", 32'(pmb_rst), 32'h0);
        ctrl(2'b01);
        check("pulse_busy", 32'(busy), 32'h1);
        measure_pulse(4'hF, n, bad);
        check("pulse_len", 32'(n), 32'd16);
        check("pulse_pwr_hold", 32'(bad), 32'd0);

        // SHDN ignored during RST_HOLD, RST restarts the count
        ctrl(2'b01);
        tick();
        tick();
        ctrl(2'b10);
        ctrl(2'b01);
        measure_pulse(4'hF, n, bad);
        check("restart_len", 32'(n), 32'd16);
        check("restart_pwr_hold", 32'(bad), 32'd0);
        check("restart_no_shdn", 32'(pmb_shdn), 32'h0);
        bus_read(4'h8, rd);
        check("restart_dom_en", rd, 32'hF);

        // RST and SHDN together: RST wins
        ctrl(2'b11);
        measure_pulse(4'hF, n, bad);
        check("both_len", 32'(n), 32'd16);
        check("both_no_shdn", 32'(pmb_shdn), 32'h0);
        bus_read(4'h8, rd);
        check("both_dom_en", rd, 32'hF);

`ifdef BOA_PMU_KEY_EN
        bus_write(4'h0, 4'hF, 32'h0000_0001);
        check("key_bad_nopulse", 32'(pmb_rst), 32'h0);
        bus_read(4'h4, rd);
        check("key_err_set", rd, 32'h8000_0F00);
        bus_write(4'h0, 4'hF, 32'hB0A5_0001);
        measure_pulse(4'hF, n, bad);
        check("key_good_pulse", 32'(n), 32'd16);
        bus_read(4'h4, rd);
        check("key_err_clr", rd, 32'h0000_0F00);
`endif

        // Register access table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].we, tbl[i].data);
            end else begin
                bus_read(tbl[i].addr, rd);
                check($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
            end
        end
        check("tbl_idle", 32'(busy), 32'h0);

        // DELAY=0: one step per 2 cycles; DOMAIN_EN write mid-STEP applies at next IDLE
        bus_write(4'hC, 4'hF, 32'h0);
        bus_write(4'h8, 4'hF, 32'hE);
        wait_change(4'hF, 10, n);
        check("d0_lat", 32'(n), 32'd1);
        check("d0_val", 32'(pwr_en), 32'hE);
        bus_write(4'h8, 4'hF, 32'h5);
        wait_change(4'hE, 10, n);
        check("d0_gap_a", 32'(n), 32'd1);
        check("d0_val_a", 32'(pwr_en), 32'hF);
        wait_change(4'hF, 10, n);
        check("d0_gap_b", 32'(n), 32'd2);
        check("d0_val_b", 32'(pwr_en), 32'hD);
        wait_change(4'hD, 10, n);
        check("d0_gap_c", 32'(n), 32'd2);
        check("d0_val_c", 32'(pwr_en), 32'h5);
        tick();
        check("d0_idle", 32'(busy), 32'h0);

        // DELAY write mid-STEP leaves the running count alone
        bus_write(4'hC, 4'hF, 32'd3);
        bus_write(4'h8, 4'hF, 32'hF);
        wait_change(4'h5, 10, n);
        check("dly_val_a", 32'(pwr_en), 32'h7);
        bus_write(4'hC, 4'hF, 32'd20);
        wait_change(4'h7, 40, n);
        check("dly_gap", 32'(n), 32'd3);
        check("dly_val_b", 32'(pwr_en), 32'hF);
        bus_write(4'hC, 4'hF, 32'd3);
        wait_idle(100, n);
        check("dly_settle", 32'(busy), 32'h0);

        // RST preempts shutdown after the first step
        ctrl(2'b10);
        wait_change(4'hF, 20, n);
        check("pre_gap", 32'(n), 32'd3);
        check("pre_val", 32'(pwr_en), 32'h7);
        ctrl(2'b01);
        measure_pulse(4'h7, n, bad);
        check("pre_pulse_len", 32'(n), 32'd16);
        check("pre_pwr_hold", 32'(bad), 32'd0);
        bus_read(4'h4, rd);
        check("pre_status", rd, 32'h0000_0700);
        bus_read(4'h8, rd);
        check("pre_dom_en", rd, 32'h0);
        wait_idle(100, n);
        check("pre_drain", 32'(pwr_en), 32'h0);
        bus_write(4'h8, 4'hF, 32'hF);
        wait_idle(100, n);
        check("pre_restore", 32'(pwr_en), 32'hF);

        // Full shutdown at DELAY=3
        ctrl(2'b10);
        for (int i = 0; i < 4; i++) begin
            wait_change(pwr_en, 20, n);
            check($sformatf("shdn_gap%0d", i), 32'(n), 32'd3);
            check($sformatf("shdn_val%0d", i), 32'(pwr_en), 32'(shdn_steps[i]));
        end
        check("shdn_not_yet", 32'(pmb_shdn), 32'h0);
        tick();
        check("shdn_assert", 32'(pmb_shdn), 32'h1);
        bus_read(4'h4, rd);
        check("off_status", rd, 32'h0000_0003);
        ctrl(2'b01);
        check("off_no_pulse", 32'(pmb_rst), 32'h0);
        bus_write(4'h8, 4'hF, 32'hF);
        for (int i = 0; i < 5; i++) tick();
        check("off_pwr", 32'(pwr_en), 32'h0);
        bus_read(4'h8, rd);
        check("off_dom_en", rd, 32'h0);
        check("off_shdn_sticky", 32'(pmb_shdn), 32'h1);

        // Async reset from OFF and mid-pulse
        bus_read(4'h4, rd);
        rst = 1'b0;
        #2;
        check("arst_shdn", 32'(pmb_shdn), 32'h0);
        check("arst_rdata", bus_rdata, 32'h0);
        check("arst_pwr", 32'(pwr_en), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_restart", 32'(pwr_en), 32'h1);
        ctrl(2'b01);
        check("arst_pulse_on", 32'(pmb_rst), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pulse_off", 32'(pmb_rst), 32'h0);
        check("arst_pwr2", 32'(pwr_en), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boa_peri_pmu_seq.md
Name: boa_peri_pmu_seq

Overview:
Parametrised successor to the single-register PMU. Memory-mapped power sequencer on the peripheral bus. Drives a timed system-reset pulse and an ordered shutdown sequence, and switches DOMAINS power domains one at a time with a programmable inter-step delay. Sits between the CPU peripheral bus and the board/PMU power-control pins.

Parameters:
DOMAINS, 4, number of switchable power domains (1..16)
DELAY_W, 16, width of step-delay counter
DEF_DELAY, 100, reset value of DELAY register (cycles)
RST_CYCLES, 16, length of pmb_rst pulse in cycles (>=1)
RESET_DOMAINS, {DOMAINS{1'b1}}, reset value of DOMAIN_EN register

Ports:
clk  in  1  CPU clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
bus_re  in  1  read strobe
bus_we  in  4  byte write enables
bus_addr  in  4  byte address; word select = bus_addr[3:2]
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
bus_ready  out  1  constant 1
pmb_rst  out  1  system reset request pulse
pmb_shdn  out  1  system shutdown, sticky
pwr_en  out  DOMAINS  domain power enables
busy  out  1  sequencer not in IDLE, or pwr_en != DOMAIN_EN

Behaviour:
- Registers (word index):
  - 0 CTRL: W bit0 = RST request, bit1 = SHDN request, write-1 effective, self-clearing. Read returns 0.
  - 1 STATUS (RO): [1:0] state code, [8+DOMAINS-1:8] pwr_en.
  - 2 DOMAIN_EN (RW): [DOMAINS-1:0] target enables.
  - 3 DELAY (RW): [DELAY_W-1:0].
- Writes honour bus_we byte lanes. Unused bits read 0.
- bus_rdata is updated the cycle after bus_re and holds until the next read.
- Reset values: pmb_rst=0, pmb_shdn=0, pwr_en=0, bus_rdata=0, state=IDLE, DELAY=DEF_DELAY, DOMAIN_EN=RESET_DOMAINS, counter=0.
- States (code):
  - IDLE(0): if any bit pwr_en[i] != DOMAIN_EN[i], toggle the lowest such i, load counter=max(DELAY,1), go to STEP.
  - STEP(1): decrement counter; at 1 go to IDLE. Exactly one domain changes per max(DELAY,1)+1 cycles.
  - RST_HOLD(2): pmb_rst=1 for exactly RST_CYCLES cycles starting the cycle after the CTRL write, then IDLE. pwr_en and registers are unchanged.
  - SHDN_SEQ(3): DOMAIN_EN is forced to 0. Clear the highest set pwr_en bit every max(DELAY,1) cycles. When pwr_en==0, assert pmb_shdn on the next cycle and enter OFF.
  - OFF (STATUS code 3, pmb_shdn=1): all writes and requests ignored until rst.
- Priorities:
  - RST and SHDN both set in one write: RST wins; SHDN is dropped.
  - RST request preempts STEP and SHDN_SEQ. On exit from a preempted SHDN_SEQ, DOMAIN_EN stays 0 (partial power-down is retained).
  - SHDN request during RST_HOLD is ignored. A RST request during RST_HOLD restarts the pulse count.
  - DOMAIN_EN write during STEP: takes effect at the next IDLE evaluation; no glitch on pwr_en.
  - DELAY write mid-STEP: the running count is unaffected.
- Async reset mid-sequence: all outputs return to reset values immediately.

Optional Feature:
BOA_PMU_KEY_EN:
- Defined: a CTRL write acts only if bus_wdata[31:16]==16'hB0A5 and bus_we[3:2]==2'b11. A write with a wrong key sets sticky STATUS bit 31 (key_err), cleared by a correct-key write.
- Undefined: no key check; STATUS[31] reads 0.

Test Plan:
- Reset release, RESET_DOMAINS=4'hF, DELAY=100 -> pwr_en goes 0001,0011,0111,1111 at 101-cycle spacing; busy drops after the last step.
- Write CTRL=1 -> pmb_rst high for exactly 16 cycles starting the next cycle; pwr_en unchanged at 4'hF.
- DELAY=3, pwr_en=4'hF, write CTRL=2 -> pwr_en 0111,0011,0001,0000 every 3 cycles; pmb_shdn=1 one cycle after 0000; later writes ignored.
- Write CTRL=3 -> RST pulse only, pmb_shdn stays 0; DELAY=0 with DOMAIN_EN toggle -> one step per 2 cycles.
- CTRL=2, then CTRL=1 after the first step -> pwr_en holds 4'h7, RST pulse runs, state returns to IDLE, DOMAIN_EN reads 0.
- With BOA_PMU_KEY_EN: CTRL=32'h0000_0001 -> no pulse, STATUS[31]=1; CTRL=32'hB0A5_0001 -> pulse, STATUS[31]=0.
